cfg_lut_bank: RTL and testbench
===============================

// Module: cfg_lut_bank
// PURPOSE
// - Bank of N K-input LUT cells. All masks and modes load at runtime over a serial configuration chain.
// - Each cell has an optional output register with a configurable initial value.
// - Runtime-programmable successor to the fixed-mask LUT and flip-flop primitives.
// - Sits inside the overlay logic cluster. The config controller drives it; several banks can be daisy-chained.
// PARAMETERS
// - K           6                    inputs per LUT
// - N           4                    LUT cells in the bank
// - SLICE_BITS  2**K+2               derived localparam: mask + reg_sel + init per cell
// - FRAME_BITS  N*SLICE_BITS         derived localparam: bits in one full configuration frame
// PORTS
// - clock      in   1     single clock, all state on posedge
// - reset      in   1     synchronous, active-high
// - cfg_start  in   1     pulse: discard current config, enter LOADING
// - cfg_valid  in   1     cfg_data valid this cycle
// - cfg_data   in   1     serial config bit, frame MSB first
// - cfg_ready  out  1     bank accepts a config bit (LOADING only)
// - cfg_done   out  1     frame complete, bank ACTIVE
// - cfg_out    out  1     serial chain output (see CONFIGURATION)
// - in         in   N*K   LUT inputs, cell i uses in[i*K +: K]
// - out        out  N     cell outputs
// BEHAVIOUR
// - Reset: state UNCONFIG; frame register, bit counter and cell FFs cleared to 0.
//   Outputs after reset: out=0, cfg_ready=0, cfg_done=0, cfg_out=0.
// - States: UNCONFIG -(cfg_start)-> LOADING -(FRAME_BITS-th accepted bit)-> ACTIVE.
//   - cfg_start from any state -> LOADING with counter=0.
//   - Frame register is not cleared on cfg_start; old contents shift out.
// - Accept = cfg_valid & cfg_ready. On accept:
//   - frame <= {frame[FRAME_BITS-2:0], cfg_data};
//   - counter increments.
//   - cfg_valid low stalls the load and holds the counter.
// - cfg_start and cfg_valid in the same cycle: start wins and the data bit is dropped.
// - cfg_valid in UNCONFIG or ACTIVE: ignored, no shift.
// - Frame layout: cell i = frame[i*SLICE_BITS +: SLICE_BITS].
//   - Within the slice: [2**K-1:0] mask, [2**K] reg_sel, [2**K+1] init.
//   - Mask MSB corresponds to all inputs high.
// - Completion: the cycle the FRAME_BITS-th bit is accepted, state <= ACTIVE and every cell FF <= its init bit.
//   - cfg_done=1 and cfg_ready=0 from the next cycle.
// - ACTIVE:
//   - lut_i = mask_i[in_i], combinational.
//   - ff_i <= lut_i every clock.
//   - out[i] = reg_sel_i ? ff_i : lut_i.
//   - Comb cells: zero latency. Registered cells: 1 cycle.
// - Not ACTIVE: out forced to 0 and cell FFs hold their value.
// - Reset mid-load: back to UNCONFIG with counter 0. Reload requires a new cfg_start.
// - Counter width: $clog2(FRAME_BITS+1). No wrap; it stops at FRAME_BITS.
// CONFIGURATION
// - CFG_CHAIN_EN defined:
//   - cfg_out = registered frame[FRAME_BITS-1], updated only on accept.
//   - Each accept emits the previous frame's bit, MSB first, to the next bank.
// - CFG_CHAIN_EN undefined: cfg_out tied 0. The port still exists and the frame register has no tap.
// STRUCTURE
// - Package lut_cfg_pkg holds:
//   - state enum {UNCONFIG, LOADING, ACTIVE};
//   - function slice_bits(K);
//   - offset constants MASK_LSB, REGSEL_OFS, INIT_OFS.
// - Sub-module cfg_lut_cell (K): mask, reg_sel, init, load_init, active, in -> out.
//   - Holds one LUT, its FF and the output mux.
//   - Instantiated N times in a generate loop.
// - Top level holds the FSM, bit counter and frame shift register.
// TESTING (K=2, N=2: SLICE_BITS=6, FRAME_BITS=12)
// - Reset: reset=1 for 2 cycles -> out=2'b00, cfg_ready=0, cfg_done=0, cfg_out=0.
// - Load and compute: cfg_start, then shift 12'b110110_001000 MSB first.
//   - Cell0 is comb AND; cell1 is registered XOR with init 1.
//   - cfg_done=1 after the 12th accepted bit, and out[1]=1 (init).
//   - in0=2'b11 -> out[0]=1 same cycle; in0=2'b01 -> out[0]=0.
//   - in1=2'b01 -> out[1]=1 one clock later; in1=2'b11 -> out[1]=0 one clock later.
// - Stall: drop cfg_valid for 5 cycles after bit 6 -> counter holds at 6, cfg_done stays 0 and rises only after bit 12.
// - Reconfigure: cfg_start while ACTIVE -> next cycle out=0, cfg_ready=1, cfg_done=0.
//   - cfg_start with cfg_valid=1 in that cycle -> counter stays 0.
// - Reset mid-load: reset after bit 7 -> UNCONFIG, counter 0; cfg_valid pulses ignored until cfg_start.
// - CFG_CHAIN_EN: reload after the load test -> cfg_out emits 1,1,0,1,1,0,0,0,1,0,0,0 on successive accepts; with the macro undefined, cfg_out stays 0.

Source files
------------

// File: rtl/lut_cfg_pkg.sv
// Shared types and slice layout for the runtime-configurable LUT bank.
// Offsets of reg_sel and init are relative to the end of the 2**K mask.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    UNCONFIG,
    LOADING,
    ACTIVE
  } state_e;

  localparam int MASK_LSB   = 0;
  localparam int REGSEL_OFS = 0;
  localparam int INIT_OFS   = 1;

  function automatic int slice_bits(input int k);
    return (2 ** k) + 2;
  endfunction

endpackage

// File: rtl/cfg_lut_cell.sv
// One K-input LUT with optional output register and init value.
// Register holds while the bank is not active.
module cfg_lut_cell
  import lut_cfg_pkg::*;
#(
  parameter int K = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [2**K-1:0] mask,
  input  logic           reg_sel,
  input  logic           init,
  input  logic           load_init,
  input  logic           active,
  input  logic [K-1:0]   in,
  output logic           out
);

  logic lut;
  logic ff_q;
  logic ff_d;

  // lookup, next FF value and output mux
  always_comb begin
    lut  = mask[in];
    ff_d = ff_q;
    if (load_init) begin
      ff_d = init;
    end else if (active) begin
      ff_d = lut;
    end
    out = 1'b0;
    if (active) begin
      out = reg_sel ? ff_q : lut;
    end
  end

  // cell register
  always_ff @(posedge clock) begin
    if (reset) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end

endmodule

// File: rtl/cfg_lut_bank.sv
// Bank of N runtime-configured LUT cells fed by a serial frame.
// Macro CFG_CHAIN_EN: register the frame MSB out for daisy-chaining.
module cfg_lut_bank
  import lut_cfg_pkg::*;
#(
  parameter int K = 6,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_data,
  output logic           cfg_ready,
  output logic           cfg_done,
  output logic           cfg_out,
  input  logic [N*K-1:0] in,
  output logic [N-1:0]   out
);

  localparam int MW         = 2 ** K;
  localparam int SLICE_BITS = slice_bits(K);
  localparam int FRAME_BITS = N * SLICE_BITS;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  accept;
  logic                  load_init;
  logic                  active;

  assign cfg_ready = (state_q == LOADING);
  assign cfg_done  = (state_q == ACTIVE);
  assign active    = (state_q == ACTIVE);

  // FSM, bit counter and frame shift; start beats a same-cycle bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    accept    = cfg_valid & cfg_ready & ~cfg_start;
    load_init = 1'b0;
    if (cfg_start) begin
      state_d = LOADING;
      cnt_d   = '0;
    end else if (accept) begin
      frame_d = {frame_q[FRAME_BITS-2:0], cfg_data};
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(FRAME_BITS - 1)) begin
        state_d   = ACTIVE;
        load_init = 1'b1;
      end
    end
  end

  // control and frame registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= UNCONFIG;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

`ifdef CFG_CHAIN_EN
  logic cfg_out_q, cfg_out_d;

  // old frame MSB leaves on every accepted bit
  always_comb begin
    cfg_out_d = cfg_out_q;
    if (accept) begin
      cfg_out_d = frame_q[FRAME_BITS-1];
    end
  end

  // chain output register
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_out_q <= 1'b0;
    end else begin
      cfg_out_q <= cfg_out_d;
    end
  end

  assign cfg_out = cfg_out_q;
`else
  assign cfg_out = 1'b0;
`endif

  // init comes from frame_d so the last shifted bit is included
  for (genvar i = 0; i < N; i++) begin : g_cell
    cfg_lut_cell #(
      .K(K)
    ) u_cell (
      .clock    (clock),
      .reset    (reset),
      .mask     (frame_q[i*SLICE_BITS+MASK_LSB +: MW]),
      .reg_sel  (frame_q[i*SLICE_BITS+MW+REGSEL_OFS]),
      .init     (frame_d[i*SLICE_BITS+MW+INIT_OFS]),
      .load_init(load_init),
      .active   (active),
      .in       (in[i*K +: K]),
      .out      (out[i])
    );
  end

endmodule

// File: tb/tb_cfg_lut_bank.sv
// Directed checks for cfg_lut_bank at K=2, N=2.
// Chain expectations follow CFG_CHAIN_EN.
module tb_cfg_lut_bank;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_data = 1'b0;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_out;
  logic [3:0] in = 4'b0000;
  logic [1:0] out;

  int nvec = 0;
  int nerr = 0;

  localparam logic [11:0] FRAME = 12'b110110_001000;

`ifdef CFG_CHAIN_EN
  localparam logic [11:0] EMIT_RELOAD = 12'b110110_001000;
`else
  localparam logic [11:0] EMIT_RELOAD = 12'b000000_000000;
`endif

  cfg_lut_bank #(
    .K(2),
    .N(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .cfg_out  (cfg_out),
    .in       (in),
    .out      (out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pulse(input logic with_bit);
    cfg_start = 1'b1;
    cfg_valid = with_bit;
    cfg_data  = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic o);
    cfg_valid = 1'b1;
    cfg_data  = b;
    tick();
    o = cfg_out;
    cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [11:0] f, input int stall_at,
                      output logic [11:0] em);
    logic o;
    em = '0;
    for (int i = 11; i >= 0; i--) begin
      if (11 - i == stall_at) begin
        repeat (5) tick();
        chk("stall_done", int'(cfg_done), 0);
        chk("stall_ready", int'(cfg_ready), 1);
      end
      if (i == 0) chk("done_before_last", int'(cfg_done), 0);
      send_bit(f[i], o);
      em = {em[10:0], o};
    end
    chk("done_after_last", int'(cfg_done), 1);
    chk("ready_after_last", int'(cfg_ready), 0);
  endtask

  initial begin
    logic [11:0] em;
    logic        o;

    repeat (2) tick();
    chk("rst_out", int'(out), 0);
    chk("rst_ready", int'(cfg_ready), 0);
    chk("rst_done", int'(cfg_done), 0);
    chk("rst_cfg_out", int'(cfg_out), 0);
    reset = 1'b0;

    send_bit(1'b1, o);
    chk("unconfig_ready", int'(cfg_ready), 0);
    chk("unconfig_done", int'(cfg_done), 0);

    start_pulse(1'b0);
    chk("load_ready", int'(cfg_ready), 1);
    chk("load_done", int'(cfg_done), 0);
    load(FRAME, 6, em);
    chk("emit_first", int'(em), 0);
    chk("init_out1", int'(out[1]), 1);

    in = 4'b01_11;
    #1;
    chk("and_11", int'(out[0]), 1);
    chk("reg_hold_init", int'(out[1]), 1);
    tick();
    chk("xor_01", int'(out[1]), 1);
    in = 4'b11_01;
    #1;
    chk("and_01", int'(out[0]), 0);
    chk("reg_lag", int'(out[1]), 1);
    tick();
    chk("xor_11", int'(out[1]), 0);

    in = 4'b01_11;
    #1;
    chk("pre_reconf_out0", int'(out[0]), 1);
    start_pulse(1'b1);
    chk("reconf_out", int'(out), 0);
    chk("reconf_ready", int'(cfg_ready), 1);
    chk("reconf_done", int'(cfg_done), 0);
    load(FRAME, -1, em);
    chk("emit_reload", int'(em), int'(EMIT_RELOAD));
    chk("reload_and", int'(out[0]), 1);

    start_pulse(1'b0);
    for (int i = 11; i >= 5; i--) send_bit(FRAME[i], o);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", int'(cfg_ready), 0);
    chk("midrst_done", int'(cfg_done), 0);
    chk("midrst_out", int'(out), 0);
    chk("midrst_cfg_out", int'(cfg_out), 0);
    repeat (3) send_bit(1'b1, o);
    chk("ignored_ready", int'(cfg_ready), 0);
    chk("ignored_done", int'(cfg_done), 0);
    start_pulse(1'b0);
    load(FRAME, -1, em);
    chk("emit_after_rst", int'(em), 0);
    in = 4'b00_11;
    #1;
    chk("final_and", int'(out[0]), 1);
    chk("final_init", int'(out[1]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
